// File: rtl/ipml_fifo_burst_reader.sv
// Burst reader: pops a fixed number of words from a prefetch FIFO into a one-deep
// registered output stage. Define IPML_BURST_READER_TIMEOUT_EN to add the starvation timeout.
module ipml_fifo_burst_reader #(
  parameter int c_DATA_WIDTH     = 32,
  parameter int c_LEN_WIDTH      = 12,
  parameter int c_TIMEOUT_CYCLES = 255
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    start,
  input  logic [c_LEN_WIDTH-1:0]  burst_len,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                    fifo_rd_vld,
  output logic                    fifo_rd_en,
  output logic [c_DATA_WIDTH-1:0] out_data,
  output logic                    out_vld,
  output logic                    out_last,
  input  logic                    out_rdy,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | popping words and presenting them downstream
  // DONE  | one-cycle completion pulse (aborted also high after a timeout)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  if (c_TIMEOUT_CYCLES < 1 || c_TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("c_TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [c_LEN_WIDTH-1:0] remaining;
  logic                   pop;
  logic                   accept;
  logic                   timeout_hit;

  assign pop    = fifo_rd_en & fifo_rd_vld;
  assign accept = out_vld & out_rdy;

`ifdef IPML_BURST_READER_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        starve;
  logic        abort_q;

  assign starve      = fifo_rd_en & ~fifo_rd_vld;
  assign timeout_hit = starve & (to_cnt == 16'(c_TIMEOUT_CYCLES - 1));

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      to_cnt <= '0;
    end else if (state != RUN || pop || timeout_hit) begin
      to_cnt <= '0;
    end else if (starve) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Registered so it lines up with the DONE cycle that the timeout causes.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= timeout_hit;
    end
  end

  assign aborted = abort_q;
`else
  assign timeout_hit = 1'b0;
  assign aborted     = 1'b0;
`endif

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((accept && out_last) || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // fifo_rd_en looks straight through to out_rdy so a full stage can refill on the accept cycle.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    fifo_rd_en = (state == RUN) && (remaining != '0) && (!out_vld || out_rdy);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      remaining <= '0;
    end else if (state == IDLE && start) begin
      remaining <= burst_len;
    end else if (timeout_hit) begin
      remaining <= '0;
    end else if (pop) begin
      remaining <= remaining - c_LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      out_data <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else if (timeout_hit) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else if (pop) begin
      out_data <= fifo_rd_data;
      out_vld  <= 1'b1;
      out_last <= (remaining == c_LEN_WIDTH'(1));
    end else if (accept) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ipml_fifo_burst_reader.sv
// Directed bench for ipml_fifo_burst_reader: a FIFO source model feeds numbered words and a
// queue of expected words/last flags, filled at each start, is checked on every accepted word.
module tb_ipml_fifo_burst_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        start;
  logic [11:0] burst_len;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_vld;
  logic        fifo_rd_en;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_last;
  logic        out_rdy;
  logic        busy;
  logic        done;
  logic        aborted;

  ipml_fifo_burst_reader #(
    .c_DATA_WIDTH    (32),
    .c_LEN_WIDTH     (12),
    .c_TIMEOUT_CYCLES(8)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .start       (start),
    .burst_len   (burst_len),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_vld (fifo_rd_vld),
    .fifo_rd_en  (fifo_rd_en),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_last    (out_last),
    .out_rdy     (out_rdy),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] src;
  logic [31:0] exp_next;
  logic        pop_now;

  int          pops, accepts, en_cnt, vld_seen, done_cnt, abort_cnt, abort_done_cnt, hold_cnt;
  int          first_acc, last_acc, done_cyc, last_pop_cyc, start_cyc, idle_cyc;
  logic        hold_pend;
  logic [31:0] hold_data;
  logic        hold_last;

  // stimulus modes applied inside run_until_idle
  logic        rdy_toggle;
  logic        inj_restart;
  logic        drop_vld_after2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    pops = 0; accepts = 0; en_cnt = 0; vld_seen = 0; done_cnt = 0;
    abort_cnt = 0; abort_done_cnt = 0; hold_cnt = 0;
    first_acc = -1; last_acc = -1; done_cyc = -1; last_pop_cyc = -1; idle_cyc = -1;
    hold_pend = 1'b0; hold_data = '0; hold_last = 1'b0;
  endtask

  task automatic observe();
    exp_t e;
    pop_now = fifo_rd_en & fifo_rd_vld;
    if (fifo_rd_en) en_cnt++;
    if (out_vld) vld_seen++;
    if (hold_pend) begin
      hold_cnt++;
      chk("hold_vld", out_vld, 1'b1);
      chk("hold_data", out_data, hold_data);
      chk("hold_last", out_last, hold_last);
    end
    hold_pend = out_vld & ~out_rdy;
    hold_data = out_data;
    hold_last = out_last;
    if (out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_word_expected", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
      end
      accepts++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (aborted) abort_cnt++;
    if (aborted && done) abort_done_cnt++;
    if (pop_now) begin
      pops++;
      last_pop_cyc = cyc;
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle();
    #1 observe();
    @(posedge rd_clk);
    @(negedge rd_clk);
    cyc++;
    if (pop_now) src = src + 32'd1;
    fifo_rd_data = src;
  endtask

  task automatic start_burst(input int len);
    for (int i = 0; i < len; i++) begin
      sb.push_back({exp_next, (i == len - 1)});
      exp_next = exp_next + 32'd1;
    end
    start_cyc = cyc;
    start     = 1'b1;
    burst_len = 12'(len);
    cycle();
    start     = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      if (rdy_toggle) out_rdy = ~out_rdy;
      if (inj_restart) begin
        start     = (n == 1 || n == 3);
        burst_len = 12'd7;
      end
      if (drop_vld_after2 && pops >= 2) fifo_rd_vld = 1'b0;
      cycle();
      n++;
    end
    start    = 1'b0;
    idle_cyc = cyc;
    chk({tag, "_reached_idle"}, busy, 1'b0);
  endtask

  task automatic reset_pulse_and_flush();
    #2 rd_rst = 1'b1;
    #1;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    sb.delete();
    src          = src + 32'h100;
    exp_next     = src;
    fifo_rd_data = src;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_rst = 1'b1; start = 1'b0; burst_len = '0; fifo_rd_vld = 1'b0; out_rdy = 1'b0;
    src = 32'h0000_1000; exp_next = src; fifo_rd_data = src;
    rdy_toggle = 1'b0; inj_restart = 1'b0; drop_vld_after2 = 1'b0;
    clr_stats();

    #3;
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_vld", out_vld, 1'b0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_fifo_rd_en", fifo_rd_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_aborted", aborted, 1'b0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    @(negedge rd_clk);

    // 4-word burst, continuous data and ready
    clr_stats();
    fifo_rd_vld = 1'b1; out_rdy = 1'b1;
    start_burst(4);
    run_until_idle(30, "b4");
    chk("b4_accepts", accepts, 4);
    chk("b4_pops", pops, 4);
    chk("b4_consecutive", last_acc - first_acc, 3);
    chk("b4_done_after_last", done_cyc, last_acc + 1);
    chk("b4_done_count", done_cnt, 1);
    chk("b4_idle_after_done", idle_cyc, done_cyc + 1);
    chk("b4_sb_empty", sb.size(), 0);

    // 3-word burst with ready toggling
    clr_stats();
    out_rdy = 1'b1; rdy_toggle = 1'b1;
    start_burst(3);
    run_until_idle(30, "b3");
    rdy_toggle = 1'b0; out_rdy = 1'b1;
    chk("b3_accepts", accepts, 3);
    chk("b3_pops", pops, 3);
    chk("b3_rd_en_cycles", en_cnt, 3);
    chk("b3_holds_seen", hold_cnt > 0, 1'b1);
    chk("b3_done_count", done_cnt, 1);
    chk("b3_sb_empty", sb.size(), 0);

    // zero-length burst
    clr_stats();
    start_burst(0);
    run_until_idle(10, "b0");
    chk("b0_done_after_start", done_cyc, start_cyc + 1);
    chk("b0_done_count", done_cnt, 1);
    chk("b0_no_out_vld", vld_seen, 0);
    chk("b0_no_rd_en", en_cnt, 0);

    // restart requests while busy are ignored
    clr_stats();
    inj_restart = 1'b1;
    start_burst(5);
    run_until_idle(40, "b5");
    inj_restart = 1'b0;
    chk("b5_accepts", accepts, 5);
    chk("b5_pops", pops, 5);
    chk("b5_done_count", done_cnt, 1);
    chk("b5_sb_empty", sb.size(), 0);
    repeat (3) cycle();
    chk("b5_stays_idle", busy, 1'b0);

    // reset after two of eight words
    clr_stats();
    start_burst(8);
    for (int n = 0; n < 20 && accepts < 2; n++) cycle();
    chk("b8_two_accepted", accepts, 2);
    reset_pulse_and_flush();
    clr_stats();
    repeat (4) cycle();
    chk("b8_no_done", done_cnt, 0);
    chk("b8_no_out_vld", vld_seen, 0);
    clr_stats();
    start_burst(2);
    run_until_idle(20, "b2");
    chk("b2_accepts", accepts, 2);
    chk("b2_done_count", done_cnt, 1);
    chk("b2_sb_empty", sb.size(), 0);

    // starvation after two words
    clr_stats();
    fifo_rd_vld = 1'b1; drop_vld_after2 = 1'b1;
`ifdef IPML_BURST_READER_TIMEOUT_EN
    start_burst(4);
    run_until_idle(40, "to");
    chk("to_pops", pops, 2);
    chk("to_accepts", accepts, 2);
    chk("to_done_count", done_cnt, 1);
    chk("to_aborted_with_done", abort_done_cnt, 1);
    chk("to_aborted_count", abort_cnt, 1);
    chk("to_done_timing", done_cyc, last_pop_cyc + 9);
    chk("to_idle_after_done", idle_cyc, done_cyc + 1);
    sb.delete();
`else
    start_burst(4);
    repeat (30) begin
      if (pops >= 2) fifo_rd_vld = 1'b0;
      cycle();
    end
    chk("starve_pops", pops, 2);
    chk("starve_busy_held", busy, 1'b1);
    chk("starve_no_done", done_cnt, 0);
    chk("starve_no_aborted", abort_cnt, 0);
    reset_pulse_and_flush();
`endif
    drop_vld_after2 = 1'b0;
    fifo_rd_vld = 1'b1;
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ipml_fifo_burst_reader.md
IPML_FIFO_BURST_READER -- requirements
Module: ipml_fifo_burst_reader

Interface
REQ-001 SHALL have parameter c_DATA_WIDTH, default 32, word width of the FIFO read port and output port.
REQ-002 SHALL have parameter c_LEN_WIDTH, default 12, width of the burst length field.
REQ-003 SHALL have parameter c_TIMEOUT_CYCLES, default 255, starvation limit in cycles, legal range 1..65535.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-high: rd_clk  input  1  sole clock, rising edge; rd_rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  burst request, sampled only in IDLE.
REQ-006 burst_len  input  c_LEN_WIDTH  number of words to transfer, captured with start.
REQ-007 fifo_rd_data  input  c_DATA_WIDTH  prefetch FIFO read data.
REQ-008 fifo_rd_vld  input  1  prefetch FIFO read data valid.
REQ-009 fifo_rd_en  output  1  pop request to the prefetch FIFO.
REQ-010 out_data  output  c_DATA_WIDTH  registered output word.
REQ-011 out_vld  output  1  out_data valid.
REQ-012 out_last  output  1  final word of the burst, qualified by out_vld.
REQ-013 out_rdy  input  1  downstream accept.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  single-cycle burst completion pulse.
REQ-016 aborted  output  1  single-cycle pulse coincident with done when the burst ended by timeout.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DONE.
REQ-018 IDLE -> RUN when start=1: capture burst_len into remaining counter; burst_len=0 SHALL go IDLE -> DONE instead, with no word output.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 fifo_rd_en SHALL be (state==RUN) & (remaining!=0) & (~out_vld | out_rdy), combinational from out_rdy.
REQ-021 A pop SHALL be fifo_rd_en & fifo_rd_vld; on pop: out_data <= fifo_rd_data, out_vld <= 1, out_last <= (remaining==1), remaining decrements by 1.
REQ-022 Latency: a word popped in cycle N SHALL appear on out_data in cycle N+1.
REQ-023 out_vld & out_rdy without pop SHALL clear out_vld; with simultaneous pop, out_vld SHALL stay 1 with the new word, sustaining one word per cycle.
REQ-024 out_data/out_last SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-025 RUN -> DONE on the cycle out_vld & out_rdy & out_last.
REQ-026 DONE SHALL last exactly one cycle with done=1, then go to IDLE; a new start is accepted from the following cycle.
REQ-027 No word SHALL be popped beyond burst_len; the FIFO SHALL never be popped in IDLE or DONE.

Reset
REQ-028 rd_rst=1 SHALL immediately force state IDLE, remaining=0, timeout counter=0, out_data=0, out_vld=0, out_last=0, fifo_rd_en=0, busy=0, done=0, aborted=0.
REQ-029 Reset mid-burst SHALL discard the pending output word; no done pulse SHALL be generated for the interrupted burst.

Configuration
REQ-030 Macro IPML_BURST_READER_TIMEOUT_EN SHALL compile in starvation timeout.
REQ-031 With the macro defined: a counter increments each RUN cycle with fifo_rd_en=1 and fifo_rd_vld=0, clears on pop; on reaching c_TIMEOUT_CYCLES, SHALL go to DONE with done=1 and aborted=1, clearing out_vld (pending word dropped).
REQ-032 With the macro undefined: no counter logic; aborted SHALL be tied 0; RUN waits indefinitely for data.

Verification
REQ-033 burst_len=4, fifo_rd_vld=1 continuously, out_rdy=1 -> 4 words on consecutive cycles, out_last on word 4, done 1 cycle after the last acceptance, busy deasserted after done.
REQ-034 burst_len=3, out_rdy toggling 1,0,1,0 -> out_data held stable during out_rdy=0, exactly 3 pops, no extra fifo_rd_en.
REQ-035 burst_len=0 -> done pulse 1 cycle after start, out_vld never asserted, fifo_rd_en never asserted.
REQ-036 start asserted again during a 5-word burst -> ignored; exactly 5 words output, single done.
REQ-037 rd_rst pulsed after 2 of 8 words -> all outputs 0 immediately, no done; a subsequent burst_len=2 completes normally.
REQ-038 With IPML_BURST_READER_TIMEOUT_EN, c_TIMEOUT_CYCLES=8, burst_len=4, fifo_rd_vld dropped after word 2 -> done=1 and aborted=1 after 8 starved cycles, then IDLE; without macro -> busy remains 1.
